// File: rtl/mips_pc_pkg.sv
// Shared encodings, counter constants and BHT index function for PC resolution.
// Pure definitions: no latency, no backpressure.
package mips_pc_pkg;

    localparam int ACTION_W = 2;
    localparam int COND_W   = 3;
    localparam int CTR_W    = 2;

    typedef enum logic [ACTION_W-1:0] {
        ACT_INC      = 2'd0,
        ACT_BRANCH   = 2'd1,
        ACT_JUMP     = 2'd2,
        ACT_REGISTER = 2'd3
    } action_e;

    typedef enum logic [COND_W-1:0] {
        COND_NONE = 3'd0,
        COND_EQ   = 3'd1,
        COND_NE   = 3'd2,
        COND_LTZ  = 3'd3,
        COND_GEZ  = 3'd4,
        COND_LEZ  = 3'd5,
        COND_GTZ  = 3'd6,
        COND_RSVD = 3'd7
    } cond_e;

    localparam logic [CTR_W-1:0] CTR_RESET = 2'b01;
    localparam logic [CTR_W-1:0] CTR_MAX   = 2'b11;
    localparam logic [CTR_W-1:0] CTR_MIN   = 2'b00;

    // Word-aligned index; lookup and update must both go through this.
    function automatic logic [31:0] bht_index(input logic [63:0] pc, input int idx_w);
        return 32'((pc >> 2) & ((64'd1 << idx_w) - 64'd1));
    endfunction

    function automatic logic cond_true(input cond_e c, input logic z, input logic n);
        case (c)
            COND_EQ:  return z;
            COND_NE:  return !z;
            COND_LTZ: return n;
            COND_GEZ: return !n;
            COND_LEZ: return n | z;
            COND_GTZ: return !n & !z;
            default:  return 1'b1;
        endcase
    endfunction

    function automatic logic is_conditional(input cond_e c);
        return (c != COND_NONE) && (c != COND_RSVD);
    endfunction

endpackage

// File: rtl/mips_pc_bht.sv
// Branch history table of 2-bit saturating counters, one async read, one update port.
// Read is combinational (no bypass of a same-cycle write); update commits on the clock edge; never stalls.
module mips_pc_bht
    import mips_pc_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [CTR_W-1:0] ctr [DEPTH];

    assign rd_taken = ctr[rd_idx][CTR_W-1];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= CTR_RESET;
            end
        end else if (wr_en) begin
            if (wr_taken) begin
                if (ctr[wr_idx] != CTR_MAX) begin
                    ctr[wr_idx] <= ctr[wr_idx] + 2'd1;
                end
            end else if (ctr[wr_idx] != CTR_MIN) begin
                ctr[wr_idx] <= ctr[wr_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/mips_datapath_signal_pc_resolve.sv
// End-of-execute branch resolution: final PC action, mispredict redirect, BHT training, statistics.
// Latency 1 cycle; no backpressure, a new instruction is accepted every cycle.
module mips_datapath_signal_pc_resolve
    import mips_pc_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int STAT_W    = 16
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              flush,
    input  logic              inValid,
    input  logic [ADDR_W-1:0] inPc,
    input  logic [ADDR_W-1:0] inTarget,
    input  logic [1:0]        actionIn,
    input  logic [2:0]        condition,
    input  logic              statusZero,
    input  logic              statusNeg,
    input  logic              predTaken,
    input  logic [ADDR_W-1:0] lookupPc,
    output logic              lookupTaken,
    output logic              outValid,
    output logic [1:0]        actionOut,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirectPc,
    output logic [STAT_W-1:0] branchCount,
    output logic [STAT_W-1:0] mispredictCount
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    action_e           act_in;
    cond_e             cond_in;
    action_e           resolved;
    logic              accept;
    logic              is_branch;
    logic              taken;
    logic              mispredict;
    logic              bht_upd;
    logic [ADDR_W-1:0] next_pc;
    logic [IDX_W-1:0]  lookup_idx;
    logic [IDX_W-1:0]  exec_idx;

    // Pending BHT write, committed one edge after resolution.
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_taken;

    assign act_in     = action_e'(actionIn);
    assign cond_in    = cond_e'(condition);
    assign lookup_idx = IDX_W'(bht_index(64'(lookupPc), IDX_W));
    assign exec_idx   = IDX_W'(bht_index(64'(inPc), IDX_W));

    always_comb begin
        accept     = inValid & !flush;
        is_branch  = (act_in == ACT_BRANCH);
        resolved   = act_in;
        if (is_branch && !cond_true(cond_in, statusZero, statusNeg)) begin
            resolved = ACT_INC;
        end
        taken      = (resolved != ACT_INC);
        mispredict = is_branch && (taken != predTaken);
        bht_upd    = is_branch && is_conditional(cond_in);
        next_pc    = taken ? inTarget : inPc + ADDR_W'(4);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            outValid   <= 1'b0;
            actionOut  <= ACT_INC;
            redirect   <= 1'b0;
            redirectPc <= '0;
            wr_en      <= 1'b0;
            wr_idx     <= '0;
            wr_taken   <= 1'b0;
        end else begin
            outValid <= accept;
            redirect <= accept & mispredict;
            wr_en    <= accept & bht_upd;
            if (accept) begin
                actionOut  <= resolved;
                redirectPc <= next_pc;
                wr_idx     <= exec_idx;
                wr_taken   <= taken;
            end
        end
    end

    // Statistics update alongside the registered result, saturating at all-ones.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            branchCount     <= '0;
            mispredictCount <= '0;
        end else if (accept) begin
            if (is_branch && (branchCount != '1)) begin
                branchCount <= branchCount + 1'b1;
            end
            if (mispredict && (mispredictCount != '1)) begin
                mispredictCount <= mispredictCount + 1'b1;
            end
        end
    end

    mips_pc_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clock    (clock),
        .resetN   (resetN),
        .rd_idx   (lookup_idx),
        .rd_taken (lookupTaken),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_taken (wr_taken)
    );

endmodule

// File: tb/tb_mips_datapath_signal_pc_resolve.sv
// Directed table-driven bench for the PC resolution stage, plus hand sequences for BHT timing,
// flush, saturation and asynchronous reset.
module tb_mips_datapath_signal_pc_resolve;

    localparam int STAT_MAX = 15;

    logic        clock = 1'b0;
    logic        resetN;
    logic        flush;
    logic        inValid;
    logic [31:0] inPc;
    logic [31:0] inTarget;
    logic [1:0]  actionIn;
    logic [2:0]  condition;
    logic        statusZero;
    logic        statusNeg;
    logic        predTaken;
    logic [31:0] lookupPc;
    logic        lookupTaken;
    logic        outValid;
    logic [1:0]  actionOut;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [3:0]  branchCount;
    logic [3:0]  mispredictCount;

    mips_datapath_signal_pc_resolve #(
        .ADDR_W    (32),
        .BHT_DEPTH (64),
        .STAT_W    (4)
    ) dut (
        .clock           (clock),
        .resetN          (resetN),
        .flush           (flush),
        .inValid         (inValid),
        .inPc            (inPc),
        .inTarget        (inTarget),
        .actionIn        (actionIn),
        .condition       (condition),
        .statusZero      (statusZero),
        .statusNeg       (statusNeg),
        .predTaken       (predTaken),
        .lookupPc        (lookupPc),
        .lookupTaken     (lookupTaken),
        .outValid        (outValid),
        .actionOut       (actionOut),
        .redirect        (redirect),
        .redirectPc      (redirectPc),
        .branchCount     (branchCount),
        .mispredictCount (mispredictCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  act;
        logic [2:0]  cond;
        logic        n;
        logic        z;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [1:0]  exp_act;
        logic        exp_redir;
        logic [31:0] exp_rpc;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    int total = 0;
    int fails = 0;
    int m_br  = 0;
    int m_mp  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Drive one instruction before a rising edge and return just after it.
    task automatic issue(input logic [1:0] a, input logic [2:0] c, input logic n, input logic z,
                         input logic p, input logic [31:0] pc, input logic [31:0] tgt, input logic fl);
        @(negedge clock);
        inValid    = 1'b1;
        flush      = fl;
        actionIn   = a;
        condition  = c;
        statusNeg  = n;
        statusZero = z;
        predTaken  = p;
        inPc       = pc;
        inTarget   = tgt;
        @(posedge clock);
        #1;
        inValid = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
    endtask

    task automatic stats(input string nm, input logic is_br, input logic is_mp);
        if (is_br && m_br < STAT_MAX) m_br++;
        if (is_mp && m_mp < STAT_MAX) m_mp++;
        chk({nm, ".branchCount"}, 32'(branchCount), 32'(m_br));
        chk({nm, ".mispredictCount"}, 32'(mispredictCount), 32'(m_mp));
    endtask

    task automatic look(input string nm, input logic [31:0] pc, input logic exp);
        lookupPc = pc;
        #1;
        chk(nm, 32'(lookupTaken), 32'(exp));
    endtask

    initial begin
        // act cond N Z pred pc tgt | exp_act exp_redir exp_rpc
        vecs[0]  = '{2'd1, 3'd3, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h2000, 2'd0, 1'b1, 32'h1004};
        vecs[1]  = '{2'd1, 3'd3, 1'b0, 1'b1, 1'b1, 32'h1000, 32'h2000, 2'd0, 1'b1, 32'h1004};
        vecs[2]  = '{2'd1, 3'd3, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h2000, 2'd1, 1'b0, 32'h2000};
        vecs[3]  = '{2'd1, 3'd4, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h2000, 2'd1, 1'b0, 32'h2000};
        vecs[4]  = '{2'd1, 3'd4, 1'b0, 1'b1, 1'b1, 32'h1000, 32'h2000, 2'd1, 1'b0, 32'h2000};
        vecs[5]  = '{2'd1, 3'd4, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h2000, 2'd0, 1'b1, 32'h1004};
        vecs[6]  = '{2'd1, 3'd5, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h2000, 2'd0, 1'b1, 32'h1004};
        vecs[7]  = '{2'd1, 3'd5, 1'b0, 1'b1, 1'b1, 32'h1000, 32'h2000, 2'd1, 1'b0, 32'h2000};
        vecs[8]  = '{2'd1, 3'd5, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h2000, 2'd1, 1'b0, 32'h2000};
        vecs[9]  = '{2'd1, 3'd6, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h2000, 2'd1, 1'b0, 32'h2000};
        vecs[10] = '{2'd1, 3'd6, 1'b0, 1'b1, 1'b1, 32'h1000, 32'h2000, 2'd0, 1'b1, 32'h1004};
        vecs[11] = '{2'd1, 3'd6, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h2000, 2'd0, 1'b1, 32'h1004};
        vecs[12] = '{2'd2, 3'd1, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h2000, 2'd2, 1'b0, 32'h2000};
        vecs[13] = '{2'd3, 3'd2, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h2000, 2'd3, 1'b0, 32'h2000};
        vecs[14] = '{2'd0, 3'd1, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h2000, 2'd0, 1'b0, 32'h1004};
        vecs[15] = '{2'd1, 3'd7, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h2000, 2'd1, 1'b1, 32'h2000};
        vecs[16] = '{2'd1, 3'd0, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h2000, 2'd1, 1'b0, 32'h2000};
        vecs[17] = '{2'd1, 3'd2, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h2000, 2'd1, 1'b1, 32'h2000};
        vecs[18] = '{2'd1, 3'd1, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h2000, 2'd0, 1'b1, 32'h1004};
        vecs[19] = '{2'd2, 3'd6, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h2000, 2'd2, 1'b0, 32'h2000};

        resetN = 1'b0; flush = 1'b0; inValid = 1'b0; inPc = '0; inTarget = '0;
        actionIn = '0; condition = '0; statusZero = 1'b0; statusNeg = 1'b0;
        predTaken = 1'b0; lookupPc = '0;
        #12 resetN = 1'b1;
        #1;

        chk("reset.outValid", 32'(outValid), 32'd0);
        chk("reset.redirect", 32'(redirect), 32'd0);
        chk("reset.actionOut", 32'(actionOut), 32'd0);
        chk("reset.redirectPc", redirectPc, 32'd0);
        stats("reset", 1'b0, 1'b0);
        look("reset.lookup_0x100", 32'h100, 1'b0);

        // BEQ taken, predicted not-taken; commit-cycle lookup sees the old counter.
        issue(2'd1, 3'd1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h200, 1'b0);
        chk("beq.outValid", 32'(outValid), 32'd1);
        chk("beq.actionOut", 32'(actionOut), 32'd1);
        chk("beq.redirect", 32'(redirect), 32'd1);
        chk("beq.redirectPc", redirectPc, 32'h200);
        stats("beq", 1'b1, 1'b1);
        look("beq.lookup_commit_cycle", 32'h100, 1'b0);
        idle();
        chk("beq.redirect_one_cycle", 32'(redirect), 32'd0);
        chk("beq.outValid_one_cycle", 32'(outValid), 32'd0);
        look("beq.lookup_after_commit", 32'h100, 1'b1);

        // BNE not taken twice drives idx 0x10 down to 00 and keeps it there.
        issue(2'd1, 3'd2, 1'b0, 1'b1, 1'b0, 32'h40, 32'h80, 1'b0);
        chk("bne.actionOut", 32'(actionOut), 32'd0);
        chk("bne.redirect", 32'(redirect), 32'd0);
        stats("bne1", 1'b1, 1'b0);
        issue(2'd1, 3'd2, 1'b0, 1'b1, 1'b0, 32'h40, 32'h80, 1'b0);
        stats("bne2", 1'b1, 1'b0);
        idle();
        look("bne.sat_low", 32'h40, 1'b0);
        issue(2'd1, 3'd2, 1'b0, 1'b0, 1'b1, 32'h40, 32'h80, 1'b0);
        chk("bne_t.redirect", 32'(redirect), 32'd0);
        stats("bne_t1", 1'b1, 1'b0);
        issue(2'd1, 3'd2, 1'b0, 1'b0, 1'b1, 32'h40, 32'h80, 1'b0);
        stats("bne_t2", 1'b1, 1'b0);
        idle();
        look("bne.back_to_10", 32'h40, 1'b1);

        // Jump with a false EQ condition passes through and leaves the BHT alone.
        issue(2'd2, 3'd1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h500, 1'b0);
        chk("jump.actionOut", 32'(actionOut), 32'd2);
        chk("jump.redirect", 32'(redirect), 32'd0);
        stats("jump", 1'b0, 1'b0);
        idle();
        look("jump.no_bht", 32'h80, 1'b0);

        // Flush together with valid on a mispredicting branch.
        issue(2'd1, 3'd1, 1'b0, 1'b1, 1'b0, 32'h180, 32'h600, 1'b1);
        chk("flush.outValid", 32'(outValid), 32'd0);
        chk("flush.redirect", 32'(redirect), 32'd0);
        stats("flush", 1'b0, 1'b0);
        idle();
        look("flush.no_bht", 32'h180, 1'b0);

        // Not-taken redirect wraps past the top of the address space.
        issue(2'd1, 3'd1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h700, 1'b0);
        chk("wrap.redirect", 32'(redirect), 32'd1);
        chk("wrap.redirectPc", redirectPc, 32'h0);
        stats("wrap", 1'b1, 1'b1);

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].act, vecs[i].cond, vecs[i].n, vecs[i].z, vecs[i].pred,
                  vecs[i].pc, vecs[i].tgt, 1'b0);
            chk($sformatf("vec%0d.outValid", i), 32'(outValid), 32'd1);
            chk($sformatf("vec%0d.actionOut", i), 32'(actionOut), 32'(vecs[i].exp_act));
            chk($sformatf("vec%0d.redirect", i), 32'(redirect), 32'(vecs[i].exp_redir));
            if (vecs[i].exp_redir) begin
                chk($sformatf("vec%0d.redirectPc", i), redirectPc, vecs[i].exp_rpc);
            end
            stats($sformatf("vec%0d", i), vecs[i].act == 2'd1, vecs[i].exp_redir);
        end

        // Back-to-back mispredicts, statistics saturate at 4 bits.
        for (int i = 0; i < 20; i++) begin
            issue(2'd1, 3'd1, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h3000, 1'b0);
            chk($sformatf("b2b%0d.redirect", i), 32'(redirect), 32'd1);
            stats($sformatf("b2b%0d", i), 1'b1, 1'b1);
        end
        chk("sat.mispredictCount", 32'(mispredictCount), 32'd15);

        // Asynchronous reset mid-cycle with a BHT write pending.
        issue(2'd1, 3'd1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h400, 1'b0);
        chk("prerst.redirect", 32'(redirect), 32'd1);
        #2 resetN = 1'b0;
        #1;
        chk("arst.outValid", 32'(outValid), 32'd0);
        chk("arst.redirect", 32'(redirect), 32'd0);
        chk("arst.actionOut", 32'(actionOut), 32'd0);
        chk("arst.redirectPc", redirectPc, 32'd0);
        m_br = 0;
        m_mp = 0;
        stats("arst", 1'b0, 1'b0);
        look("arst.bht_0x40", 32'h40, 1'b0);
        resetN = 1'b1;
        lookupPc = 32'h300;
        idle();
        look("arst.pending_dropped", 32'h300, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", total, fails);
        $finish;
    end

endmodule
